// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V main-decoder FSM with parametrised ALU decoder
module multicycle_control #(
  parameter int ALU_CTRL_W   = 4,
  parameter bit EN_SHIFT_XOR = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [6:0]            op_i,
  input  logic [2:0]            f3_i,
  input  logic [6:0]            f7_i,
  input  logic                  zero_i,
  output logic                  pc_write_o,
  output logic                  adr_src_o,
  output logic                  mem_write_o,
  output logic                  ir_write_o,
  output logic [1:0]            result_src_o,
  output logic [1:0]            alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [1:0]            imm_src_o,
  output logic                  reg_write_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  instr_done_o,
  output logic                  illegal_o
);

  localparam bit SHX = EN_SHIFT_XOR && (ALU_CTRL_W >= 4);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;

  state_t     state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic [3:0] funct_alu;
  logic       funct_ok;
  logic [3:0] alu;
  logic       pc_update, branch, mem_write, ir_write, reg_write, done, ill;

  // ALU operation from funct fields; funct_ok flags encodings this build cannot execute
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (f3_i)
      3'b000: funct_alu = (op_i[5] && f7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b010: funct_alu = ALU_SLT;
      3'b011: begin funct_alu = ALU_SLTU; funct_ok = SHX; end
      3'b100: begin funct_alu = ALU_XOR;  funct_ok = SHX; end
      3'b110: funct_alu = ALU_OR;
      3'b111: funct_alu = ALU_AND;
      3'b001: begin funct_alu = ALU_SLL;  funct_ok = SHX && (f7_i == 7'b0000000); end
      default: begin funct_alu = f7_i[5] ? ALU_SRA : ALU_SRL; funct_ok = SHX; end
    endcase
    if (op_i == OP_R && f7_i != 7'b0000000 && f7_i != 7'b0100000) funct_ok = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    is_sw_d      = is_sw_q;
    pc_update    = 1'b0;
    branch       = 1'b0;
    adr_src_o    = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    reg_write    = 1'b0;
    alu          = ALU_ADD;
    done         = 1'b0;
    ill          = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write     = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        is_sw_d     = op_i[5];
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = funct_ok ? S_EXECR : S_ILLEGAL;
          OP_I:         state_d = funct_ok ? S_EXECI : S_ILLEGAL;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = is_sw_q ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write    = 1'b1;
        done         = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_o = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu         = funct_alu;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu         = funct_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu         = ALU_SUB;
        branch      = 1'b1;
        done        = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update   = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ILLEGAL: ill = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    case (op_i)
      OP_SW:   imm_src_o = 2'b01;
      OP_BEQ:  imm_src_o = 2'b10;
      OP_JAL:  imm_src_o = 2'b11;
      default: imm_src_o = 2'b00;
    endcase
  end

  // Side-effecting strobes are held off for the whole reset cycle, wherever the FSM was
  assign pc_write_o    = ~reset_i & (pc_update | (branch & zero_i));
  assign mem_write_o   = ~reset_i & mem_write;
  assign ir_write_o    = ~reset_i & ir_write;
  assign reg_write_o   = ~reset_i & reg_write;
  assign instr_done_o  = ~reset_i & done;
  assign illegal_o     = ~reset_i & ill;
  assign alu_control_o = alu[ALU_CTRL_W-1:0];

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized model-checked bench for multicycle_control
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r4, r3, zero;
  logic [6:0] op, f7;
  logic [2:0] f3;

  logic       pcw4, adr4, mw4, irw4, rw4, done4, ill4;
  logic [1:0] rs4, sa4, sb4, imm4;
  logic [3:0] alu4;
  logic       pcw3, adr3, mw3, irw3, rw3, done3, ill3;
  logic [1:0] rs3, sa3, sb3, imm3;
  logic [2:0] alu3;

  multicycle_control #(.ALU_CTRL_W(4), .EN_SHIFT_XOR(1'b1)) dut4 (
    .clk_i(clk), .reset_i(r4), .op_i(op), .f3_i(f3), .f7_i(f7), .zero_i(zero),
    .pc_write_o(pcw4), .adr_src_o(adr4), .mem_write_o(mw4), .ir_write_o(irw4),
    .result_src_o(rs4), .alu_src_a_o(sa4), .alu_src_b_o(sb4), .imm_src_o(imm4),
    .reg_write_o(rw4), .alu_control_o(alu4), .instr_done_o(done4), .illegal_o(ill4));

  multicycle_control #(.ALU_CTRL_W(3), .EN_SHIFT_XOR(1'b1)) dut3 (
    .clk_i(clk), .reset_i(r3), .op_i(op), .f3_i(f3), .f7_i(f7), .zero_i(zero),
    .pc_write_o(pcw3), .adr_src_o(adr3), .mem_write_o(mw3), .ir_write_o(irw3),
    .result_src_o(rs3), .alu_src_a_o(sa3), .alu_src_b_o(sb3), .imm_src_o(imm3),
    .reg_write_o(rw3), .alu_control_o(alu3), .instr_done_o(done3), .illegal_o(ill3));

  // Packed as {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
  //            imm_src, reg_write, alu_control, instr_done, illegal}
  localparam logic [18:0] RMASK = ~19'b1_0_1_1_00_00_00_00_1_0000_1_1;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;
  localparam int T_F = 0, T_D = 1, T_MA = 2, T_MR = 3, T_MWB = 4, T_MW = 5,
                 T_XR = 6, T_XI = 7, T_AWB = 8, T_BQ = 9, T_J = 10, T_IL = 11;

  int          sel = 0;
  logic        chk = 1'b0;
  logic [18:0] exp_v = '0;
  string       tag = "reset";
  int          n_vec = 0, n_err = 0;

  wire [18:0] act4 = {pcw4, adr4, mw4, irw4, rs4, sa4, sb4, imm4, rw4, alu4, done4, ill4};
  wire [18:0] act3 = {pcw3, adr3, mw3, irw3, rs3, sa3, sb3, imm3, rw3, 1'b0, alu3, done3, ill3};

  always @(negedge clk) begin
    if (chk) begin
      logic [18:0] act;
      act = (sel != 0) ? act3 : act4;
      n_vec++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL %s @%0t: outputs got %b want %b", tag, $time, act, exp_v);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int classify(input logic [6:0] o, input logic [2:0] a, input logic [6:0] b,
                                  input bit shx, output logic [3:0] alu);
    bit ok;
    alu = 4'd0;
    ok  = 1'b1;
    if (o == 7'b0000011) return K_LW;
    if (o == 7'b0100011) return K_SW;
    if (o == 7'b1100011) return K_BEQ;
    if (o == 7'b1101111) return K_JAL;
    if (o != 7'b0110011 && o != 7'b0010011) return K_ILL;
    case (a)
      3'd0: alu = (o[5] && b[5]) ? 4'd1 : 4'd0;
      3'd1: begin alu = 4'd6; ok = shx && (b == 7'd0); end
      3'd2: alu = 4'd5;
      3'd3: begin alu = 4'd9; ok = shx; end
      3'd4: begin alu = 4'd4; ok = shx; end
      3'd5: begin alu = b[5] ? 4'd8 : 4'd7; ok = shx; end
      3'd6: alu = 4'd3;
      default: alu = 4'd2;
    endcase
    if (o == 7'b0110011 && b != 7'h00 && b != 7'h20) ok = 1'b0;
    if (!ok) return K_ILL;
    return o[5] ? K_R : K_I;
  endfunction

  function automatic int flow_len(input int kind);
    case (kind)
      K_LW:  return 5;
      K_BEQ: return 3;
      K_ILL: return 3;
      default: return 4;
    endcase
  endfunction

  // Which step of the instruction flow cycle k belongs to
  function automatic int step_of(input int kind, input int k);
    if (k == 0) return T_F;
    if (k == 1) return T_D;
    case (kind)
      K_LW:  return (k == 2) ? T_MA : (k == 3) ? T_MR : T_MWB;
      K_SW:  return (k == 2) ? T_MA : T_MW;
      K_R:   return (k == 2) ? T_XR : T_AWB;
      K_I:   return (k == 2) ? T_XI : T_AWB;
      K_BEQ: return T_BQ;
      K_JAL: return (k == 2) ? T_J : T_AWB;
      default: return T_IL;
    endcase
  endfunction

  function automatic logic [18:0] step_vec(input int t, input logic [3:0] alu, input logic z,
                                           input logic [6:0] o);
    logic pcw, adr, mw, irw, rw, dn, il;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] ac;
    {pcw, adr, mw, irw, rw, dn, il} = '0;
    {rs, sa, sb} = '0;
    ac = 4'd0;
    case (t)
      T_F:   begin irw = 1; pcw = 1; rs = 2'b10; sb = 2'b10; end
      T_D:   begin sa = 2'b01; sb = 2'b01; end
      T_MA:  begin sa = 2'b10; sb = 2'b01; end
      T_MR:  adr = 1;
      T_MWB: begin rs = 2'b01; rw = 1; dn = 1; end
      T_MW:  begin adr = 1; mw = 1; dn = 1; end
      T_XR:  begin sa = 2'b10; ac = alu; end
      T_XI:  begin sa = 2'b10; sb = 2'b01; ac = alu; end
      T_AWB: begin rw = 1; dn = 1; end
      T_BQ:  begin sa = 2'b10; ac = 4'd1; pcw = z; dn = 1; end
      T_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: il = 1;
    endcase
    case (o)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, ac, dn, il};
  endfunction

  task automatic cyc(input logic [18:0] e, input logic rst);
    if (sel != 0) r3 = rst; else r4 = rst;
    exp_v = rst ? (e & RMASK) : e;
    chk   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // zmode: 0/1 fixed zero, 2 random; cut: cycle index at which reset is asserted (-1 none)
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] a,
                           input logic [6:0] b, input int zmode, input int cut, input int hold);
    logic [3:0] alu;
    int kind, n;
    tag  = name;
    op   = o;
    f3   = a;
    f7   = b;
    kind = classify(o, a, b, sel == 0, alu);
    n    = flow_len(kind) + ((kind == K_ILL) ? hold : 0);
    for (int k = 0; k < n; k++) begin
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      if (k == cut) begin
        cyc(step_vec(step_of(kind, k), alu, zero, o), 1'b1);
        return;
      end
      cyc(step_vec(step_of(kind, k), alu, zero, o), 1'b0);
    end
    if (kind == K_ILL) cyc(step_vec(T_IL, alu, zero, o), 1'b1);
  endtask

  task automatic random_instrs(input int count);
    logic [6:0] o, b;
    logic [6:0] ops [6];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    for (int i = 0; i < count; i++) begin
      int pick, fsel, cut;
      pick = int'($urandom_range(0, 6));
      o    = (pick == 6) ? 7'($urandom) : ops[pick];
      fsel = int'($urandom_range(0, 3));
      b    = (fsel < 2) ? 7'h00 : (fsel == 2) ? 7'h20 : 7'($urandom);
      cut  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr("random", o, 3'($urandom), b, 2, cut, int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    logic [3:0] a;
    logic [18:0] v;
    r4 = 1'b1; r3 = 1'b1; zero = 1'b0; op = '0; f3 = '0; f7 = '0;

    check("pin_len_add", flow_len(classify(7'b0110011, 3'd0, 7'h00, 1, a)), 4);
    check("pin_len_lw",  flow_len(classify(7'b0000011, 3'd2, 7'h00, 1, a)), 5);
    check("pin_len_sw",  flow_len(classify(7'b0100011, 3'd2, 7'h00, 1, a)), 4);
    check("pin_len_beq", flow_len(classify(7'b1100011, 3'd0, 7'h00, 1, a)), 3);
    void'(classify(7'b0110011, 3'd5, 7'h20, 1, a));
    check("pin_alu_sra", a, 8);
    void'(classify(7'b0110011, 3'd0, 7'h20, 1, a));
    check("pin_alu_sub", a, 1);
    void'(classify(7'b0010011, 3'd0, 7'h20, 1, a));
    check("pin_alu_addi_f7", a, 0);
    check("pin_sra_w3_illegal", classify(7'b0110011, 3'd5, 7'h20, 0, a), K_ILL);
    v = step_vec(step_of(K_R, 3), 4'd0, 1'b0, 7'b0110011);
    check("pin_add_c4_regwrite", v[6], 1);
    check("pin_add_c4_done", v[1], 1);

    @(posedge clk);
    #1;
    tag = "reset";
    cyc(step_vec(T_F, 4'd0, 1'b0, 7'd0), 1'b1);

    run_instr("add",       7'b0110011, 3'b000, 7'h00, 0, -1, 0);
    run_instr("sub",       7'b0110011, 3'b000, 7'h20, 0, -1, 0);
    run_instr("addi_f7",   7'b0010011, 3'b000, 7'h20, 0, -1, 0);
    run_instr("lw",        7'b0000011, 3'b010, 7'h00, 0, -1, 0);
    run_instr("sw",        7'b0100011, 3'b010, 7'h00, 0, -1, 0);
    run_instr("beq_z1",    7'b1100011, 3'b000, 7'h00, 1, -1, 0);
    run_instr("beq_z0",    7'b1100011, 3'b000, 7'h00, 0, -1, 0);
    run_instr("jal",       7'b1101111, 3'b000, 7'h00, 0, -1, 0);
    run_instr("sra",       7'b0110011, 3'b101, 7'h20, 0, -1, 0);
    run_instr("sltu",      7'b0110011, 3'b011, 7'h00, 0, -1, 0);
    run_instr("slli_bad",  7'b0010011, 3'b001, 7'h20, 0, -1, 2);
    run_instr("bad_f7",    7'b0110011, 3'b000, 7'h01, 0, -1, 2);
    run_instr("op_ones",   7'b1111111, 3'b000, 7'h00, 0, -1, 10);
    run_instr("sw_reset",  7'b0100011, 3'b010, 7'h00, 0, 3, 0);
    run_instr("add_after", 7'b0110011, 3'b111, 7'h00, 0, -1, 0);
    random_instrs(400);

    chk = 1'b0;
    r4  = 1'b1;
    sel = 1;
    tag = "reset_w3";
    cyc(step_vec(T_F, 4'd0, 1'b0, 7'd0), 1'b1);
    run_instr("sra_w3",  7'b0110011, 3'b101, 7'h20, 0, -1, 10);
    run_instr("add_w3",  7'b0110011, 3'b000, 7'h00, 0, -1, 0);
    run_instr("sub_w3",  7'b0110011, 3'b000, 7'h20, 0, -1, 0);
    run_instr("slti_w3", 7'b0010011, 3'b010, 7'h55, 0, -1, 0);
    run_instr("xor_w3",  7'b0110011, 3'b100, 7'h00, 0, -1, 3);
    random_instrs(150);

    chk = 1'b0;
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
